regex_imem_arbiter: RTL
=======================

// Module: regex_imem_arbiter
// PURPOSE
//  Instruction-fetch arbiter between N_CPU regex_cpu fetch ports and one dual-port read-only instruction BRAM.
//  Each CPU raises a fetch request (valid/addr); the arbiter grants up to two requests per cycle, one per BRAM port.
//  Granted instruction words are returned to the requesting CPU exactly one cycle after its ready pulse.
//  This is the cycle in which the CPU samples memory_data in its fetch-receive state.
//  Sits directly downstream of the CPU fetch interface, upstream of the instruction BRAM.
// PARAMETERS
//  N_CPU             4   number of CPU fetch ports (>=1)
//  MEMORY_WIDTH      16  instruction word width
//  MEMORY_ADDR_WIDTH 11  BRAM address width
//  CNT_WIDTH         32  statistics counter width (only with REGEX_IMEM_ARB_STATS_EN)
// PORTS
//  clk          in   1                      clock
//  rst          in   1                      synchronous, active-high reset
//  cpu_valid    in   N_CPU                  per-CPU fetch request (CPU memory_valid)
//  cpu_addr     in   N_CPU*MEMORY_ADDR_WIDTH per-CPU fetch address, CPU i at [i*AW+:AW]
//  cpu_ready    out  N_CPU                  per-CPU grant (CPU memory_ready)
//  cpu_data     out  N_CPU*MEMORY_WIDTH     per-CPU returned word, CPU i at [i*MW+:MW]
//  bram_a_en    out  1                      port A read enable
//  bram_a_addr  out  MEMORY_ADDR_WIDTH      port A address
//  bram_a_dout  in   MEMORY_WIDTH           port A data, valid 1 cycle after en
//  bram_b_en    out  1                      port B read enable
//  bram_b_addr  out  MEMORY_ADDR_WIDTH      port B address
//  bram_b_dout  in   MEMORY_WIDTH           port B data, valid 1 cycle after en
//  stat_grants  out  CNT_WIDTH              total grants (macro only)
//  stat_stalls  out  CNT_WIDTH              total cycles with a requester left ungranted (macro only)
// BEHAVIOUR
//  - Reset: rr_ptr=0, sel_q=0, gnt_q=0, counters=0.
//    cpu_ready, bram_*_en and bram_*_addr are 0 while rst=1; cpu_data is 0 in the cycle after reset.
//  - Grant (combinational from cpu_valid and rr_ptr):
//    scan CPUs rr_ptr, rr_ptr+1, ... modulo N_CPU.
//    The first valid goes to port A, the second valid goes to port B, any others wait.
//  - cpu_ready[i]=1 only for granted i, in the same cycle. Handshake = valid & ready; there is no backpressure beyond that.
//  - bram_x_en=1 iff port x is granted. bram_x_addr = granted CPU's address; 0 when the port is idle.
//  - rr_ptr update: if any grant, rr_ptr <= (last granted index + 1) mod N_CPU; otherwise it holds.
//  - Return path: sel_q[i] <= port used by CPU i (0=A, 1=B); gnt_q[i] <= cpu_ready[i].
//    Next cycle, cpu_data[i] = gnt_q[i] ? (sel_q[i] ? bram_b_dout : bram_a_dout) : 0.
//  - Latency: grant at cycle t, data at t+1. Fixed, with no dependence on load.
//  - A CPU may be re-granted at t+1; the CPU FSM cannot re-request before t+2, so this case does not arise.
//  - Same address on both ports in one cycle: legal (read-only), both served.
//  - N_CPU=1: port B is never enabled, and rr_ptr stays 0.
//  - Starvation bound: any valid requester is granted within ceil(N_CPU/2) cycles.
//  - Reset mid-fetch: an outstanding return is dropped (gnt_q cleared); the CPUs reset in the same cycle.
//  - rr_ptr width = max(1, $clog2(N_CPU)); modulo wrap is explicit compare-to-N_CPU-1, not power-of-2 truncation.
// CONFIGURATION
//  REGEX_IMEM_ARB_STATS_EN defined:
//    stat_grants += popcount(cpu_ready) each cycle.
//    stat_stalls += 1 in any cycle where popcount(cpu_valid) > popcount(cpu_ready).
//    Both counters saturate at all-ones and clear on rst.
//  REGEX_IMEM_ARB_STATS_EN undefined: stat_* ports and counters are absent, and grant/return behaviour is identical.
// STRUCTURE
//  Package regex_imem_arb_pkg: typedef port_sel_t (PORT_A=1'b0, PORT_B=1'b1) and the function popcount.
//  Sub-module regex_rr_pick2: inputs req vector and rr_ptr.
//    Outputs gnt_a/gnt_b valid flags and indices (one-hot grant + index), purely combinational.
//  Top level holds rr_ptr, sel_q, gnt_q, the return muxes and the optional counters.
// TESTING
//  1. Single request: rst release, cpu_valid=0001, addr0=0x005.
//     -> cpu_ready=0001, bram_a_en=1, addr_a=0x005; next cycle cpu_data[0]=bram_a_dout; rr_ptr=1.
//  2. All four valid, rr_ptr=0: cycle t grants 0->A, 1->B, rr_ptr=2; cycle t+1 grants 2->A, 3->B, rr_ptr=0.
//     cpu_data[0]/[1] at t+1 from A/B respectively.
//  3. Wrap: rr_ptr=3, valid=1001 -> 3->A, 0->B, rr_ptr=1; cpu_data[3]=A_dout, cpu_data[0]=B_dout.
//  4. Same address 0x7FF on CPU1 and CPU2 -> both ports read 0x7FF; both CPUs receive identical words next cycle.
//  5. rst asserted in a grant cycle: cpu_ready=0 and en=0 during rst; all cpu_data=0 in the following cycle; rr_ptr=0.
//  6. STATS_EN, 3 requesters held valid for 10 cycles
//     -> stat_grants=20, stat_stalls=10; without the macro, the build has no stat_* ports.

Source files
------------

// File: rtl/regex_imem_arb_pkg.sv
// Shared types and helpers for the regex instruction-memory arbiter.
package regex_imem_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

    localparam int POPCNT_W = 64;

    function automatic int unsigned popcount(input logic [POPCNT_W-1:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < POPCNT_W; i++) begin
            cnt = cnt + 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regex_rr_pick2.sv
// Round-robin picker: first two requesters from rr_ptr onward, one for each BRAM port.
module regex_rr_pick2 #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic          gnt_a_valid,
    output logic [PW-1:0] gnt_a_idx,
    output logic [N-1:0]  gnt_a,
    output logic          gnt_b_valid,
    output logic [PW-1:0] gnt_b_idx,
    output logic [N-1:0]  gnt_b
);

    logic [PW:0] pos_s;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap at N so non-power-of-2 N works.
    always_comb begin
        gnt_a_valid = 1'b0;
        gnt_a_idx   = '0;
        gnt_a       = '0;
        gnt_b_valid = 1'b0;
        gnt_b_idx   = '0;
        gnt_b       = '0;
        pos_s       = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = {1'b0, rr_ptr} + (PW+1)'(k);
            if (pos_s >= (PW+1)'(N)) begin
                pos_s = pos_s - (PW+1)'(N);
            end else begin
                pos_s = pos_s;
            end
            if (req[pos_s[PW-1:0]]) begin
                if (!gnt_a_valid) begin
                    gnt_a_valid               = 1'b1;
                    gnt_a_idx                 = pos_s[PW-1:0];
                    gnt_a[pos_s[PW-1:0]]      = 1'b1;
                end else if (!gnt_b_valid) begin
                    gnt_b_valid               = 1'b1;
                    gnt_b_idx                 = pos_s[PW-1:0];
                    gnt_b[pos_s[PW-1:0]]      = 1'b1;
                end else begin
                    gnt_b_valid = gnt_b_valid;
                end
            end else begin
                gnt_a_valid = gnt_a_valid;
            end
        end
    end

endmodule

// File: rtl/regex_imem_arbiter.sv
// Arbitrates N_CPU instruction fetch ports onto a dual-port read-only BRAM, data returned one cycle after grant.
// Optional statistics counters are built when REGEX_IMEM_ARB_STATS_EN is defined.
module regex_imem_arbiter
    import regex_imem_arb_pkg::*;
#(
    parameter int N_CPU             = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_CPU-1:0]                     cpu_valid,
    input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_addr,
    output logic [N_CPU-1:0]                     cpu_ready,
    output logic [N_CPU*MEMORY_WIDTH-1:0]        cpu_data,
    output logic                                 bram_a_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]         bram_a_addr,
    input  logic [MEMORY_WIDTH-1:0]              bram_a_dout,
    output logic                                 bram_b_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]         bram_b_addr,
    input  logic [MEMORY_WIDTH-1:0]              bram_b_dout
`ifdef REGEX_IMEM_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]                 stat_grants,
    output logic [CNT_WIDTH-1:0]                 stat_stalls
`endif
);

    localparam int PW = (N_CPU > 1) ? $clog2(N_CPU) : 1;
    localparam int AW = MEMORY_ADDR_WIDTH;
    localparam int MW = MEMORY_WIDTH;

    logic [PW-1:0]    rr_ptr_r;
    port_sel_t        sel_q_r [N_CPU];
    logic [N_CPU-1:0] gnt_q_r;

    logic             a_valid_s, b_valid_s, port_a_s, port_b_s;
    logic [PW-1:0]    a_idx_s, b_idx_s, last_idx_s, rr_next_s;
    logic [N_CPU-1:0] gnt_a_s, gnt_b_s, cpu_ready_s;
    logic [AW-1:0]    addr_a_s, addr_b_s;

    regex_rr_pick2 #(.N(N_CPU), .PW(PW)) u_pick (
        .req         (cpu_valid),
        .rr_ptr      (rr_ptr_r),
        .gnt_a_valid (a_valid_s),
        .gnt_a_idx   (a_idx_s),
        .gnt_a       (gnt_a_s),
        .gnt_b_valid (b_valid_s),
        .gnt_b_idx   (b_idx_s),
        .gnt_b       (gnt_b_s)
    );

    // Grants are suppressed while rst is high; address muxes return 0 on idle ports.
    always_comb begin
        port_a_s    = a_valid_s & ~rst;
        port_b_s    = b_valid_s & ~rst;
        cpu_ready_s = rst ? '0 : (gnt_a_s | gnt_b_s);
        addr_a_s    = '0;
        addr_b_s    = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (port_a_s && (a_idx_s == PW'(i))) begin
                addr_a_s = cpu_addr[i*AW +: AW];
            end else begin
                addr_a_s = addr_a_s;
            end
            if (port_b_s && (b_idx_s == PW'(i))) begin
                addr_b_s = cpu_addr[i*AW +: AW];
            end else begin
                addr_b_s = addr_b_s;
            end
        end
        last_idx_s = b_valid_s ? b_idx_s : a_idx_s;
        rr_next_s  = (last_idx_s == PW'(N_CPU-1)) ? '0 : (last_idx_s + PW'(1));
    end

    assign cpu_ready   = cpu_ready_s;
    assign bram_a_en   = port_a_s;
    assign bram_a_addr = addr_a_s;
    assign bram_b_en   = port_b_s;
    assign bram_b_addr = addr_b_s;

    // Pointer advance and return-path bookkeeping for next-cycle data steering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
            gnt_q_r  <= '0;
            for (int i = 0; i < N_CPU; i++) begin
                sel_q_r[i] <= PORT_A;
            end
        end else begin
            if (port_a_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            gnt_q_r <= cpu_ready_s;
            for (int i = 0; i < N_CPU; i++) begin
                sel_q_r[i] <= gnt_b_s[i] ? PORT_B : PORT_A;
            end
        end
    end

    // Steer the BRAM read data to the CPU that was granted last cycle.
    always_comb begin
        cpu_data = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (gnt_q_r[i]) begin
                cpu_data[i*MW +: MW] = (sel_q_r[i] == PORT_B) ? bram_b_dout : bram_a_dout;
            end else begin
                cpu_data[i*MW +: MW] = '0;
            end
        end
    end

`ifdef REGEX_IMEM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] stat_grants_r, stat_stalls_r;
    logic [CNT_WIDTH:0]   grants_sum_s;
    logic                 stall_s;

    // Saturating sum of this cycle's grants; a stall is any requester left waiting.
    always_comb begin
        grants_sum_s = {1'b0, stat_grants_r} +
                       (CNT_WIDTH+1)'(popcount(POPCNT_W'(cpu_ready_s)));
        stall_s      = popcount(POPCNT_W'(cpu_valid)) > popcount(POPCNT_W'(cpu_ready_s));
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_r <= '0;
            stat_stalls_r <= '0;
        end else begin
            stat_grants_r <= grants_sum_s[CNT_WIDTH] ? '1 : grants_sum_s[CNT_WIDTH-1:0];
            if (stall_s && (stat_stalls_r != '1)) begin
                stat_stalls_r <= stat_stalls_r + CNT_WIDTH'(1);
            end else begin
                stat_stalls_r <= stat_stalls_r;
            end
        end
    end

    assign stat_grants = stat_grants_r;
    assign stat_stalls = stat_stalls_r;
`endif

endmodule
